// File: rtl/rr_ex_pipe_reg_if.sv
// ----------------------------------------------------------------------------
// rr_ex_pipe_reg_if
// Purpose : Bundles the RR->EX pipeline-register signals. The RR stage side
//           (master) drives the instruction fields and the EX control lines.
//           The pipeline register (slave) returns the PR3 contents and the
//           upstream freeze request.
// Signals :
//   I_RR, PC_RR, D1_RR, D2_RR [15:0]  RR instruction, PC and the two operands
//   B_RR                              RR bubble flag (1 = invalid slot)
//   Stall_EX, Flush_EX                EX hold request / EX kill request
//   I_15_0_PR3 [15:0], I_15_6_PR3 [9:0], PC_PR3, D1_PR3, D2_PR3 [15:0], B_PR3
//   Hold_RR                           freeze PC and all upstream registers
//   LU_Count [15:0]                   load-use bubble count, present only when
//                                     RR_EX_LU_STATS_EN is defined
// ----------------------------------------------------------------------------
interface rr_ex_pipe_reg_if;
    logic [15:0] I_RR;
    logic [15:0] PC_RR;
    logic [15:0] D1_RR;
    logic [15:0] D2_RR;
    logic        B_RR;
    logic        Stall_EX;
    logic        Flush_EX;

    logic [15:0] I_15_0_PR3;
    logic [9:0]  I_15_6_PR3;
    logic [15:0] PC_PR3;
    logic [15:0] D1_PR3;
    logic [15:0] D2_PR3;
    logic        B_PR3;
    logic        Hold_RR;
`ifdef RR_EX_LU_STATS_EN
    logic [15:0] LU_Count;

    modport master (
        output I_RR, PC_RR, D1_RR, D2_RR, B_RR, Stall_EX, Flush_EX,
        input  I_15_0_PR3, I_15_6_PR3, PC_PR3, D1_PR3, D2_PR3, B_PR3, Hold_RR,
               LU_Count
    );
    modport slave (
        input  I_RR, PC_RR, D1_RR, D2_RR, B_RR, Stall_EX, Flush_EX,
        output I_15_0_PR3, I_15_6_PR3, PC_PR3, D1_PR3, D2_PR3, B_PR3, Hold_RR,
               LU_Count
    );
`else
    modport master (
        output I_RR, PC_RR, D1_RR, D2_RR, B_RR, Stall_EX, Flush_EX,
        input  I_15_0_PR3, I_15_6_PR3, PC_PR3, D1_PR3, D2_PR3, B_PR3, Hold_RR
    );
    modport slave (
        input  I_RR, PC_RR, D1_RR, D2_RR, B_RR, Stall_EX, Flush_EX,
        output I_15_0_PR3, I_15_6_PR3, PC_PR3, D1_PR3, D2_PR3, B_PR3, Hold_RR
    );
`endif
endinterface

// File: rtl/rr_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// rr_ex_pipe_reg
// Purpose : The RR->EX pipeline register (PR3). It detects load-use hazards
//           and inserts exactly one bubble per hazard. When PR3 holds a load
//           whose destination is read by the RR instruction, PR3 receives a
//           bubble and upstream is frozen for one cycle. Each edge applies
//           these actions in priority order: flush, then stall, then hazard
//           bubble, then normal capture.
// Ports   :
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   rr_ex_pipe_reg_if.slave (RR inputs in, PR3 contents and Hold_RR out)
// Option  : define RR_EX_LU_STATS_EN to add bus.LU_Count. This is a
//           saturating 16-bit count of the bubbles inserted for hazards.
// ----------------------------------------------------------------------------
module rr_ex_pipe_reg (
    input  logic             clk,
    input  logic             rst,
    rr_ex_pipe_reg_if.slave  bus
);
    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam logic [3:0] OP_LW = 4'b0100;

    state_t      state_q, state_d;
    logic [15:0] i_q, pc_q, d1_q, d2_q;
    logic        b_q;

    logic [3:0]  rr_op;
    logic [2:0]  rr_ra, rr_rb, ld_dest;
    logic        reads_ra, reads_rb, pr3_is_load, hazard;

    // Hazard detection. Only the register fields that the RR opcode actually
    // reads are compared. Instructions such as LHI carry a register number in
    // [11:9] but do not read that register.
    always_comb begin
        rr_op       = bus.I_RR[15:12];
        rr_ra       = bus.I_RR[11:9];
        rr_rb       = bus.I_RR[8:6];
        ld_dest     = i_q[11:9];
        reads_ra    = rr_op inside {4'b0001, 4'b0000, 4'b0010,
                                    4'b0101, 4'b1000, 4'b1011};
        reads_rb    = rr_op inside {4'b0001, 4'b0010, 4'b0100,
                                    4'b0101, 4'b1000, 4'b1010};
        pr3_is_load = !b_q && (i_q[15:12] == OP_LW);
        // In BUBBLE the load has already been given its one bubble, so the
        // hazard is masked. The held PR3 fields would otherwise re-trigger it.
        hazard      = (state_q == RUN) && pr3_is_load && !bus.B_RR &&
                      ((reads_ra && (rr_ra == ld_dest)) ||
                       (reads_rb && (rr_rb == ld_dest)));
    end

    // NOTE: every signal written in this block gets a default first. A path
    //       that leaves a combinational output unassigned infers a latch.
    always_comb begin
        state_d = state_q;
        if (bus.Flush_EX)
            state_d = RUN;
        else if (bus.Stall_EX)
            state_d = state_q;
        else if (hazard)
            state_d = BUBBLE;
        else
            state_d = RUN;
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    //       register reads its pre-edge value regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // PR3 datapath. On a flush the fields are loaded but marked invalid.
    // On a hazard only the valid bit changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q  <= '0;
            pc_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
            b_q  <= 1'b1;
        end else if (bus.Flush_EX) begin
            i_q  <= bus.I_RR;
            pc_q <= bus.PC_RR;
            d1_q <= bus.D1_RR;
            d2_q <= bus.D2_RR;
            b_q  <= 1'b1;
        end else if (bus.Stall_EX) begin
            b_q  <= b_q;
        end else if (hazard) begin
            b_q  <= 1'b1;
        end else begin
            i_q  <= bus.I_RR;
            pc_q <= bus.PC_RR;
            d1_q <= bus.D1_RR;
            d2_q <= bus.D2_RR;
            b_q  <= bus.B_RR;
        end
    end

    assign bus.I_15_0_PR3 = i_q;
    assign bus.I_15_6_PR3 = i_q[15:6];
    assign bus.PC_PR3     = pc_q;
    assign bus.D1_PR3     = d1_q;
    assign bus.D2_PR3     = d2_q;
    assign bus.B_PR3      = b_q;
    // A flush kills the hazard. The stall term keeps upstream frozen
    // whenever EX is held.
    assign bus.Hold_RR    = bus.Stall_EX || (hazard && !bus.Flush_EX);

`ifdef RR_EX_LU_STATS_EN
    logic [15:0] lu_q;
    logic        hazard_taken;

    assign hazard_taken = hazard && !bus.Flush_EX && !bus.Stall_EX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lu_q <= '0;
        else if (hazard_taken && (lu_q != 16'hFFFF))
            lu_q <= lu_q + 16'd1;
    end

    assign bus.LU_Count = lu_q;
`endif

endmodule

// File: tb/tb_rr_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_rr_ex_pipe_reg
// Purpose : Self-checking bench for rr_ex_pipe_reg. The stimulus process
//           drives the RR inputs at the falling edge. It then asks a
//           behavioural pipeline model for the expected Hold_RR and for the
//           PR3 contents after the next edge, and queues that expectation.
//           A separate monitor pops each entry: it checks Hold_RR before the
//           edge and the PR3 outputs shortly after it. Directed scenarios add
//           constant-valued checks for the known instruction sequences.
// ----------------------------------------------------------------------------
module tb_rr_ex_pipe_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_ex_pipe_reg_if bus ();
    rr_ex_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        hold;
        logic [15:0] i, pc, d1, d2;
        logic        b;
        logic [15:0] lu;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: the PR3 slot, a flag saying the previous unstalled
    // action was a load-use bubble, and the bubble count.
    logic [15:0] m_i, m_pc, m_d1, m_d2;
    logic        m_b;
    bit          m_bubbled;
    int unsigned m_lu;

    logic [3:0] op_pool [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4,
                                 4'd4, 4'd5, 4'd8, 4'd10, 4'd11, 4'd12};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit uses_ra(input logic [3:0] op);
        return op inside {4'd1, 4'd0, 4'd2, 4'd5, 4'd8, 4'd11};
    endfunction

    function automatic bit uses_rb(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd10};
    endfunction

    function automatic bit model_hazard(input logic [15:0] i_rr, input logic b_rr);
        if (m_bubbled || m_b || b_rr || (m_i[15:12] != 4'd4))
            return 1'b0;
        return (uses_ra(i_rr[15:12]) && (i_rr[11:9] == m_i[11:9])) ||
               (uses_rb(i_rr[15:12]) && (i_rr[8:6]  == m_i[11:9]));
    endfunction

    task automatic model_reset();
        m_i = '0; m_pc = '0; m_d1 = '0; m_d2 = '0;
        m_b = 1'b1; m_bubbled = 1'b0; m_lu = 0;
    endtask

    // One clock of stimulus. This task also releases reset, so the first
    // capture after reset happens on the edge that follows this call.
    task automatic cycle(input logic [15:0] i, pc, d1, d2,
                         input logic b, stall, flush);
        exp_t e;
        bit   hz;
        @(negedge clk);
        rst          = 1'b0;
        bus.I_RR     = i;
        bus.PC_RR    = pc;
        bus.D1_RR    = d1;
        bus.D2_RR    = d2;
        bus.B_RR     = b;
        bus.Stall_EX = stall;
        bus.Flush_EX = flush;
        #1;
        hz     = model_hazard(i, b);
        e.hold = stall || (hz && !flush);
        if (flush) begin
            m_i = i; m_pc = pc; m_d1 = d1; m_d2 = d2;
            m_b = 1'b1; m_bubbled = 1'b0;
        end else if (stall) begin
            m_b = m_b;
        end else if (hz) begin
            m_b = 1'b1; m_bubbled = 1'b1;
            if (m_lu != 32'd65535) m_lu++;
        end else begin
            m_i = i; m_pc = pc; m_d1 = d1; m_d2 = d2;
            m_b = b; m_bubbled = 1'b0;
        end
        e.i = m_i; e.pc = m_pc; e.d1 = m_d1; e.d2 = m_d2; e.b = m_b;
        e.lu = 16'(m_lu);
        sb_q.push_back(e);
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: Hold_RR is checked mid-cycle, and PR3 just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_hold_rr", bus.Hold_RR, e.hold);
                @(posedge clk);
                #1;
                check("sb_i_pr3",    bus.I_15_0_PR3, e.i);
                check("sb_i_15_6",   bus.I_15_6_PR3, e.i[15:6]);
                check("sb_pc_pr3",   bus.PC_PR3, e.pc);
                check("sb_d1_pr3",   bus.D1_PR3, e.d1);
                check("sb_d2_pr3",   bus.D2_PR3, e.d2);
                check("sb_b_pr3",    bus.B_PR3, e.b);
`ifdef RR_EX_LU_STATS_EN
                check("sb_lu_count", bus.LU_Count, e.lu);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.I_RR = '0; bus.PC_RR = '0; bus.D1_RR = '0; bus.D2_RR = '0;
        bus.B_RR = 1'b1; bus.Stall_EX = 1'b0; bus.Flush_EX = 1'b0;
        model_reset();
        #12;
        check("rst_i_pr3",   bus.I_15_0_PR3, 16'h0000);
        check("rst_i_15_6",  bus.I_15_6_PR3, 10'h000);
        check("rst_pc_pr3",  bus.PC_PR3, 16'h0000);
        check("rst_d1_pr3",  bus.D1_PR3, 16'h0000);
        check("rst_d2_pr3",  bus.D2_PR3, 16'h0000);
        check("rst_b_pr3",   bus.B_PR3, 1'b1);
        check("rst_hold_rr", bus.Hold_RR, 1'b0);
`ifdef RR_EX_LU_STATS_EN
        check("rst_lu_count", bus.LU_Count, 16'h0000);
`endif

        // Basic capture of an ADD on the first edge after reset.
        cycle(16'h1298, 16'h0010, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        check("add_hold", bus.Hold_RR, 1'b0);
        post_edge();
        check("add_i",    bus.I_15_0_PR3, 16'h1298);
        check("add_i156", bus.I_15_6_PR3, 10'h04A);
        check("add_b",    bus.B_PR3, 1'b0);
        check("add_pc",   bus.PC_PR3, 16'h0010);

        // Load-use on ra: LW r5, then ADD reading r5.
        cycle(16'h4A80, 16'h0011, 16'h0A0A, 16'h0B0B, 1'b0, 1'b0, 1'b0);
        cycle(16'h1A40, 16'h0012, 16'h0C0C, 16'h0D0D, 1'b0, 1'b0, 1'b0);
        check("lu_hold", bus.Hold_RR, 1'b1);
        post_edge();
        check("lu_bubble_b", bus.B_PR3, 1'b1);
        check("lu_bubble_i", bus.I_15_0_PR3, 16'h4A80);
        cycle(16'h1A40, 16'h0012, 16'h0C0C, 16'h0D0D, 1'b0, 1'b0, 1'b0);
        check("lu_release_hold", bus.Hold_RR, 1'b0);
        post_edge();
        check("lu_add_i", bus.I_15_0_PR3, 16'h1A40);
        check("lu_add_b", bus.B_PR3, 1'b0);
`ifdef RR_EX_LU_STATS_EN
        check("lu_count_one", bus.LU_Count, 16'h0001);
`endif

        // LHI names r5 in [11:9] but does not read it, so there is no hazard.
        cycle(16'h4A80, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(16'h3A00, 16'h0021, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("lhi_hold", bus.Hold_RR, 1'b0);
        post_edge();
        check("lhi_i", bus.I_15_0_PR3, 16'h3A00);
        check("lhi_b", bus.B_PR3, 1'b0);

        // Flush overrides the hazard and leaves the FSM in RUN.
        cycle(16'h4A80, 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(16'h1A40, 16'h0031, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("flush_hold", bus.Hold_RR, 1'b0);
        post_edge();
        check("flush_b", bus.B_PR3, 1'b1);
        cycle(16'h4A80, 16'h0032, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(16'h1A40, 16'h0033, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("after_flush_hazard_hold", bus.Hold_RR, 1'b1);
        post_edge();
        check("after_flush_bubble_b", bus.B_PR3, 1'b1);

        // Now in BUBBLE: three stalls hold PR3, then reset arrives mid-cycle.
        for (int k = 0; k < 3; k++) begin
            cycle(16'h1A40, 16'h0033, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
            check("stall_hold", bus.Hold_RR, 1'b1);
            post_edge();
            check("stall_i", bus.I_15_0_PR3, 16'h4A80);
            check("stall_pc", bus.PC_PR3, 16'h0032);
            check("stall_b", bus.B_PR3, 1'b1);
        end
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_i",  bus.I_15_0_PR3, 16'h0000);
        check("arst_pc", bus.PC_PR3, 16'h0000);
        check("arst_b",  bus.B_PR3, 1'b1);
        bus.Stall_EX = 1'b0;
        #1;
        check("arst_hold", bus.Hold_RR, 1'b0);
        model_reset();
        cycle(16'h1A40, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("post_rst_hold", bus.Hold_RR, 1'b0);
        post_edge();
        check("post_rst_i", bus.I_15_0_PR3, 16'h1A40);
        check("post_rst_b", bus.B_PR3, 1'b0);

        // Randomized traffic, biased toward loads and a small register set.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ri;
            ri = {op_pool[$urandom_range(0, 11)], 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 6'($urandom)};
            cycle(ri, 16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_ex_pipe_reg.md
RR_EX_PIPE_REG -- requirements
Module: rr_ex_pipe_reg

Interface
REQ-001 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-002 SHALL have I_RR (in, 16): instruction in register-read stage; opcode is [15:12], ra is [11:9], rb is [8:6].
REQ-003 SHALL have PC_RR (in, 16), D1_RR (in, 16) and D2_RR (in, 16): PC, operand 1 and operand 2 read in RR.
REQ-004 SHALL have B_RR (in, 1): bubble flag of the RR instruction; 1 marks an invalid slot.
REQ-005 SHALL have Stall_EX (in, 1, downstream holds PR3) and Flush_EX (in, 1, branch/jump resolved, kill PR3 content).
REQ-006 SHALL have I_15_0_PR3 (out, 16), I_15_6_PR3 (out, 10, always equal to I_15_0_PR3[15:6]), PC_PR3, D1_PR3, D2_PR3 (out, 16 each) and B_PR3 (out, 1).
REQ-007 SHALL have Hold_RR (out, 1): combinational request to freeze the PC and all upstream registers this cycle.

Function
REQ-008 Two-state FSM: RUN and BUBBLE.
REQ-009 Define "PR3 is a load" as B_PR3==0 and I_15_0_PR3[15:12]==0100; the load destination is I_15_0_PR3[11:9].
REQ-010 RR reads ra when its opcode is in {0001, 0000, 0010, 0101, 1000, 1011}.
REQ-011 RR reads rb when its opcode is in {0001, 0010, 0100, 0101, 1000, 1010}.
REQ-012 Hazard = state RUN, PR3 is a load, B_RR==0, and the RR instruction reads a register equal to the load destination.
REQ-013 Per rising edge, priority is Flush_EX > Stall_EX > Hazard > normal capture.
REQ-014 Flush_EX: B_PR3 <= 1, the other PR3 fields are don't-care but loaded from RR, and state <= RUN.
REQ-015 Stall_EX (no flush): all PR3 registers hold their values and state holds.
REQ-016 Hazard (no flush, no stall): B_PR3 <= 1, the data fields hold, and state <= BUBBLE.
REQ-017 Normal capture: PR3 fields <= RR inputs, B_PR3 <= B_RR, and state <= RUN.
REQ-018 In state BUBBLE, Hazard is forced to 0, and the state returns to RUN on the next unstalled edge, so exactly one bubble is inserted per load-use.
REQ-019 Hold_RR = Stall_EX OR (Hazard AND NOT Flush_EX).
REQ-020 Hold_RR SHALL be 0 whenever Flush_EX=1 and Stall_EX=0.
REQ-021 Latency: an unstalled, hazard-free RR instruction appears on the PR3 outputs one cycle later.

Reset
REQ-022 While rst=1, asynchronously set I_15_0_PR3, PC_PR3, D1_PR3 and D2_PR3 to 0, B_PR3=1 and state=RUN.
REQ-023 Reset asserted mid-BUBBLE SHALL return the FSM to RUN with no residual Hold_RR.
REQ-024 The first capture SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro RR_EX_LU_STATS_EN, when defined, adds output LU_Count (16): a saturating count of Hazard-inserted bubbles.
REQ-026 LU_Count resets to 0, increments on each edge where Hazard is acted on, and sticks at 0xFFFF.
REQ-027 Without RR_EX_LU_STATS_EN, LU_Count and its counter SHALL be absent and the remaining behaviour is identical.

Verification
REQ-028 Basic capture: reset, then RR=ADD (I=0x1298), B_RR=0, Stall/Flush=0 -> next cycle I_15_0_PR3=0x1298, I_15_6_PR3=0x04A, B_PR3=0, Hold_RR=0.
REQ-029 Load-use on ra: PR3 holds LW with I=0x4A80 (dest r5), RR=ADD with ra=r5 -> Hold_RR=1 that cycle; next cycle B_PR3=1 and state BUBBLE; following cycle the ADD is in PR3 with B_PR3=0; LU_Count=1 when the macro is defined.
REQ-030 Dependency on a register the consumer does not use: PR3 holds LW dest r5, RR=LHI (opcode 0011) with [11:9]=r5 -> no hazard, Hold_RR=0.
REQ-031 Flush overrides hazard: same setup as REQ-029 with Flush_EX=1 -> Hold_RR=0, B_PR3=1 next cycle, state RUN.
REQ-032 Stall then reset: Stall_EX=1 for 3 cycles -> PR3 outputs unchanged and Hold_RR=1; then assert rst during BUBBLE -> outputs 0, B_PR3=1 immediately without a clock edge.
